// File: rtl/four_way_tc_scheduler.sv
// Carry-less (GF(2)[x]) N x N multiplier built from a 4-way operand split.
// One shared W x W bit-serial slice multiplier is stepped over all 16 slice pairs.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// MUL   | bit-serial product of A slice i and B slice j, one bit per cycle
// ACC   | fold the slice product into the accumulator at offset W*(i+j)
// DONE  | result presented on c, done pulses for one cycle
module four_way_tc_scheduler #(
   parameter int N = 409
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] c
);

   localparam int W  = (N + 3) / 4;
   localparam int TW = (W > 1) ? $clog2(W) : 1;
   localparam int PW = 2 * W - 1;
   localparam int AW = 8 * W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [4*W-1:0]  a_q;
   logic [4*W-1:0]  b_q;
   logic [PW-1:0]   partial;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   acc_nxt;
   logic [3:0]      p;
   logic [TW-1:0]   t;
   logic [2*N-1:0]  c_q;
   logic [W-1:0]    a_slice;
   logic [W-1:0]    b_slice;
   logic            last_bit;
   logic            last_pair;
   int              shamt;

   // p[3:2] selects the A slice, p[1:0] the B slice
   assign a_slice   = a_q[W*int'(p[3:2]) +: W];
   assign b_slice   = b_q[W*int'(p[1:0]) +: W];
   assign last_bit  = (t == TW'(W - 1));
   assign last_pair = (p == 4'd15);
   assign shamt     = W * (int'(p[3:2]) + int'(p[1:0]));
   assign acc_nxt   = acc ^ (AW'(partial) << shamt);
   assign c         = c_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = MUL;
            end
         end
         MUL: begin
            if (last_bit) begin
               state_nxt = ACC;
            end
         end
         ACC: begin
            state_nxt = last_pair ? DONE : MUL;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q     <= '0;
         b_q     <= '0;
         partial <= '0;
         acc     <= '0;
         p       <= '0;
         t       <= '0;
         c_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= (4*W)'(a);
                  b_q     <= (4*W)'(b);
                  acc     <= '0;
                  partial <= '0;
                  p       <= '0;
                  t       <= '0;
               end
            end
            MUL: begin
               if (a_slice[t]) begin
                  partial <= partial ^ (PW'(b_slice) << t);
               end
               t <= last_bit ? '0 : t + TW'(1);
            end
            ACC: begin
               acc <= acc_nxt;
               // Bits of acc at or above 2N are always zero for zero-padded operands
               if (last_pair) begin
                  c_q <= acc_nxt[2*N-1:0];
               end else begin
                  p       <= p + 4'd1;
                  t       <= '0;
                  partial <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/four_way_tc_scheduler.md
FOUR_WAY_TC_SCHEDULER -- requirements
Module: four_way_tc_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 409, meaning operand width in bits.
REQ-002 The block SHALL have derived constant W = ceil(N/4), which is 103 at the default; this is the slice width and is not user-settable.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a multiplication; sampled only in IDLE.
REQ-006 The block SHALL have port a, input, N bits: operand A; captured on the accepted start cycle.
REQ-007 The block SHALL have port b, input, N bits: operand B; captured on the accepted start cycle.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse when c becomes valid.
REQ-010 The block SHALL have port c, output, 2N bits: carry-less (GF(2)[x]) product a*b.

Function
REQ-011 The block SHALL compute c = a*b over GF(2), with XOR accumulation and no carries, using the 4-way split.
REQ-012 The block SHALL zero-extend the captured operands to 4W bits; slice k of A = A_pad[W*k +: W] for k = 0..3, and likewise for B.
REQ-013 The block SHALL contain exactly one W x W bit-serial carry-less slice multiplier, time-shared across all 16 slice pairs.
REQ-014 The block SHALL process pair index p = 0..15 with i = p/4 (A slice) and j = p%4 (B slice), in ascending p order.
REQ-015 The block SHALL use FSM states IDLE, MUL, ACC and DONE.
REQ-016 IDLE: when start=1, the block SHALL latch a and b, clear the accumulator, set p=0 and bit counter=0, and go to MUL; otherwise it SHALL stay in IDLE.
REQ-017 MUL: each cycle with bit counter t, the block SHALL XOR (B slice j << t) into the 2W-1-bit partial register if A slice i bit t = 1; it SHALL then increment t and go to ACC after t = W-1.
REQ-018 The partial register SHALL be cleared on entry to each MUL pass.
REQ-019 ACC (1 cycle): the block SHALL update the accumulator (8W bits) as accumulator ^= partial << (W*(i+j)).
REQ-020 ACC: if p = 15 the block SHALL go to DONE; otherwise it SHALL increment p, reset t to 0, and go to MUL.
REQ-021 DONE (1 cycle): the block SHALL drive c = accumulator[2N-1:0], assert done=1, then go to IDLE.
REQ-022 Latency: done SHALL be high exactly 16*(W+1)+1 cycles after the accepted start edge, which is 1665 cycles at N=409.
REQ-023 c SHALL hold its value from DONE until the DONE of the next operation; it SHALL not change during MUL or ACC.
REQ-024 start SHALL be ignored in MUL, ACC and DONE; there is no queueing.
REQ-025 A start arriving in the DONE cycle SHALL be dropped, and the earliest accepted restart is the following cycle, in IDLE.
REQ-026 Changes on a or b after acceptance SHALL not affect the running operation.
REQ-027 Accumulator bits at or above 2N SHALL be zero by construction and SHALL be discarded.
REQ-028 busy SHALL be low in IDLE and high in MUL, ACC and DONE; done SHALL be high only in DONE.

Reset
REQ-029 When rst=0 at a clock edge, the block SHALL set state to IDLE, busy=0, done=0, c=0, clear the accumulator, partial register, p and t, and clear the latched operands.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse, and c SHALL read 0 from the next cycle.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification
REQ-032 The bench SHALL check a=1, b=1, start pulse -> done at cycle 1665, c=1, busy falls the cycle after done.
REQ-033 The bench SHALL check a=3, b=3 -> c=5 (carry-less); a=2^408, b=2^408 -> c=2^816.
REQ-034 The bench SHALL check a = b = all ones (N bits) -> c equals a software clmul reference; also 1000 random pairs -> c matches the reference.
REQ-035 The bench SHALL hold start=1 continuously with a and b changing each cycle -> the first captured pair yields the correct c, the next acceptance occurs 1 cycle after done, and no start is accepted while busy=1.
REQ-036 The bench SHALL drive rst=0 at cycle 800 of an operation -> busy=0, done never pulses, and c=0; a new start then yields the correct result with full 1665-cycle latency.
REQ-037 The bench SHALL check N=16 (W=4): a=0xFFFF, b=0x0001 -> c=0xFFFF with done at 16*5+1 = 81 cycles.
